// File: rtl/exec_branch_unit_pkg.sv
// Shared definitions for the exec-stage branch unit: flag bit positions, condition codes,
// branch opcodes, resolve-FSM states and the condition evaluator.
package exec_branch_unit_pkg;

    localparam int FLAG_Z = 0;
    localparam int FLAG_S = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [2:0] {
        CC_ALWAYS = 3'd0,
        CC_Z      = 3'd1,
        CC_NS     = 3'd2,
        CC_S      = 3'd3,
        CC_C      = 3'd4,
        CC_V      = 3'd5,
        CC_NZ     = 3'd6,
        CC_NEVER  = 3'd7
    } cc_e;

    // Upper opcode bits; bit 0 selects absolute (1) or pc-relative (0) targets.
    localparam logic [5:0] OPC_BRANCH = 6'b001110;
    localparam logic [5:0] OPC_CALL   = 6'b001111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_HOLD    = 2'd2
    } state_e;

    function automatic logic cond_met(input cc_e cc, input logic z, input logic s,
                                      input logic c, input logic v);
        cond_met = 1'b0;
        case (cc)
            CC_ALWAYS: cond_met = 1'b1;
            CC_Z:      cond_met = z;
            CC_NS:     cond_met = ~s;
            CC_S:      cond_met = s;
            CC_C:      cond_met = c;
            CC_V:      cond_met = v;
            CC_NZ:     cond_met = ~z;
            CC_NEVER:  cond_met = 1'b0;
            default:   cond_met = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/exec_branch_unit_if.sv
// Issue, redirect and BHT-lookup signals between issue/fetch and the branch unit.
// link_v_o/link_addr_o exist only when BRANCH_LINK_EN is defined.
interface exec_branch_unit_if
    import exec_branch_unit_pkg::*;
#(
    parameter int ADDR    = 32,
    parameter int W_OPC   = 7,
    parameter int W_CC    = 3,
    parameter int W_FLAGS = 4
);
    logic               v_i;
    logic               ready_o;
    logic [ADDR-1:0]    pc_i;
    logic [W_OPC-1:0]   opecode_i;
    logic [W_CC-1:0]    cc;
    logic [ADDR-1:0]    opr1_i;
    logic [W_FLAGS-1:0] flags;
    logic               pred_taken_i;
    logic [ADDR-1:0]    pred_target_i;
    logic               redirect_v_o;
    logic               redirect_rdy_i;
    logic [ADDR-1:0]    redirect_addr_o;
    logic               flush_o;
    logic               taken_o;
    logic               resolve_v_o;
    logic [ADDR-1:0]    bht_rd_pc_i;
    logic               bht_pred_o;
`ifdef BRANCH_LINK_EN
    logic               link_v_o;
    logic [ADDR-1:0]    link_addr_o;
`endif

    modport slave (
`ifdef BRANCH_LINK_EN
        output link_v_o, output link_addr_o,
`endif
        input  v_i, pc_i, opecode_i, cc, opr1_i, flags, pred_taken_i, pred_target_i,
        input  redirect_rdy_i, bht_rd_pc_i,
        output ready_o, redirect_v_o, redirect_addr_o, flush_o, taken_o, resolve_v_o, bht_pred_o
    );

    modport master (
`ifdef BRANCH_LINK_EN
        input  link_v_o, input link_addr_o,
`endif
        output v_i, pc_i, opecode_i, cc, opr1_i, flags, pred_taken_i, pred_target_i,
        output redirect_rdy_i, bht_rd_pc_i,
        input  ready_o, redirect_v_o, redirect_addr_o, flush_o, taken_o, resolve_v_o, bht_pred_o
    );

endinterface

// File: rtl/exec_branch_unit_bht.sv
// Direct-mapped table of 2-bit saturating counters; prediction is the counter MSB.
// Read is combinational; update lands on the clock edge, so a same-cycle read sees the old value.
module branch_bht #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_pred_o,
    input  logic             upd_v_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);
    logic [1:0] ctr_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else if (upd_v_i) begin
            if (upd_taken_i && (ctr_q[upd_idx_i] != 2'b11)) begin
                ctr_q[upd_idx_i] <= ctr_q[upd_idx_i] + 2'd1;
            end else if (!upd_taken_i && (ctr_q[upd_idx_i] != 2'b00)) begin
                ctr_q[upd_idx_i] <= ctr_q[upd_idx_i] - 2'd1;
            end
        end
    end

    assign rd_pred_o = ctr_q[rd_idx_i][1];

endmodule

// File: rtl/exec_branch_unit.sv
// Exec-stage branch resolver: one issue per cycle, resolve/redirect/BHT update one cycle later.
// Backpressure: ready_o drops only while a redirect is held unaccepted; optional call-link via BRANCH_LINK_EN.
module exec_branch_unit
    import exec_branch_unit_pkg::*;
#(
    parameter int ADDR       = 32,
    parameter int W_OPC      = 7,
    parameter int W_CC       = 3,
    parameter int W_FLAGS    = 4,
    parameter int BHT_DEPTH  = 16,
    parameter int INSN_BYTES = 4
) (
    input logic               clk,
    input logic               rst_n,
    exec_branch_unit_if.slave bus
);
    localparam int              IDX_W = $clog2(BHT_DEPTH);
    localparam int              OFF_W = $clog2(INSN_BYTES);
    localparam logic [ADDR-1:0] STEP  = ADDR'(INSN_BYTES);

    state_e             state_q;
    logic               taken_q;
    logic               redirect_v_q;
    logic [ADDR-1:0]    redirect_addr_q;
    logic [IDX_W-1:0]   upd_idx_q;
    logic [IDX_W-1:0]   rd_idx;
    logic [W_CC-1:0]    cc_w;
    logic [W_FLAGS-1:0] flags_w;
    logic               is_call, is_br, taken, mispred, hold, flush, accept;
    logic [ADDR-1:0]    target, fall_thru, next_pc;

    always_comb begin
        cc_w    = bus.cc;
        flags_w = bus.flags;
        is_call = 1'b0;
`ifdef BRANCH_LINK_EN
        is_call = (bus.opecode_i[W_OPC-1:1] == (W_OPC-1)'(OPC_CALL));
`endif
        is_br     = (bus.opecode_i[W_OPC-1:1] == (W_OPC-1)'(OPC_BRANCH)) || is_call;
        taken     = cond_met(cc_e'(cc_w), flags_w[FLAG_Z], flags_w[FLAG_S],
                             flags_w[FLAG_C], flags_w[FLAG_V]);
        target    = bus.opecode_i[0] ? bus.opr1_i : bus.pc_i + bus.opr1_i;
        fall_thru = bus.pc_i + STEP;
        next_pc   = taken ? target : fall_thru;
        mispred   = (taken != bus.pred_taken_i) || (taken && (target != bus.pred_target_i));
        hold      = redirect_v_q && !bus.redirect_rdy_i;
        flush     = redirect_v_q && bus.redirect_rdy_i;
        // An op arriving alongside the flush is on the wrong path and never enters the pipe.
        accept    = bus.v_i && !hold && !flush && is_br;
        rd_idx    = IDX_W'(bus.bht_rd_pc_i >> OFF_W);
    end

`ifdef BRANCH_LINK_EN
    logic            link_v_q;
    logic [ADDR-1:0] link_addr_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            taken_q         <= 1'b0;
            redirect_v_q    <= 1'b0;
            redirect_addr_q <= '0;
            upd_idx_q       <= '0;
`ifdef BRANCH_LINK_EN
            link_v_q        <= 1'b0;
            link_addr_q     <= '0;
`endif
        end else begin
            taken_q <= accept && taken;
            if (accept) begin
                upd_idx_q <= IDX_W'(bus.pc_i >> OFF_W);
            end
            if (!hold) begin
                redirect_v_q <= accept && mispred;
                if (accept && mispred) begin
                    redirect_addr_q <= next_pc;
                end
            end
            if (hold) begin
                state_q <= ST_HOLD;
            end else if (accept) begin
                state_q <= ST_RESOLVE;
            end else begin
                state_q <= ST_IDLE;
            end
`ifdef BRANCH_LINK_EN
            link_v_q    <= accept && is_call;
            link_addr_q <= (accept && is_call) ? fall_thru : '0;
`endif
        end
    end

    branch_bht #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_idx_i    (rd_idx),
        .rd_pred_o   (bus.bht_pred_o),
        .upd_v_i     (state_q == ST_RESOLVE),
        .upd_idx_i   (upd_idx_q),
        .upd_taken_i (taken_q)
    );

    assign bus.ready_o         = !hold;
    assign bus.flush_o         = flush;
    assign bus.resolve_v_o     = (state_q == ST_RESOLVE);
    assign bus.taken_o         = taken_q;
    assign bus.redirect_v_o    = redirect_v_q;
    assign bus.redirect_addr_o = redirect_addr_q;
`ifdef BRANCH_LINK_EN
    assign bus.link_v_o        = link_v_q;
    assign bus.link_addr_o     = link_addr_q;
`endif

endmodule
